// File: rtl/ber_statistics_pkg.sv
// Shared types and widths for the BER statistics block.
// Also holds the saturating adder used by the three point counters.
package ber_statistics_pkg;

  localparam int CODE_LEN_DEF = 256;
  localparam int CHUNK_DEF    = 32;
  localparam int N_CHUNKS     = CODE_LEN_DEF / CHUNK_DEF;
  localparam int CNT_W        = 32;
  localparam int SIGMA_W      = 10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COUNT   = 3'd1,
    S_ACCUM   = 3'd2,
    S_CHECK   = 3'd3,
    S_REPORT  = 3'd4,
    S_RESTART = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/ber_statistics_popcount.sv
// Combinational population count of one chunk of the error vector.
module ber_popcount #(
  parameter int W = 32
) (
  input  logic [W-1:0]             i_bits,
  output logic [$clog2(W+1)-1:0]   o_count
);

  localparam int PC_W = $clog2(W+1);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < W; i++) begin
      o_count = o_count + PC_W'(i_bits[i]);
    end
  end

endmodule

// File: rtl/ber_statistics.sv
// BER accumulator for one sigma point at a time; steps sigma and restarts the chain.
// state   | meaning
// IDLE    | wait for a decoder_down rising edge
// COUNT   | popcount one chunk of the error vector per cycle, LSB chunk first
// ACCUM   | fold the frame's error count into the saturating counters
// CHECK   | decide whether the point is closed
// REPORT  | one-cycle decoder_sigma_down, step sigma
// RESTART | hold modulation_rst low, then clear counters
// DONE    | sweep finished, frozen until reset
module ber_statistics
  import ber_statistics_pkg::*;
#(
  parameter int                 CodeLen               = CODE_LEN_DEF,
  parameter int                 Chunk                 = CHUNK_DEF,
  parameter int                 Frames_Per_Sigma      = 1000,
  parameter int                 Err_Target            = 100,
  parameter int                 Sigma_Iteration_Times = 20,
  parameter logic [SIGMA_W-1:0] Sigma_Start           = 10'd600,
  parameter logic [SIGMA_W-1:0] Sigma_Step            = 10'd25,
  parameter int                 Rst_Cycles            = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               decoder_down,
  input  logic [CodeLen-1:0] prototype_sequence,
  input  logic [CodeLen-1:0] decision_information,
  output logic [SIGMA_W-1:0] sigma,
  output logic               modulation_rst,
  output logic [CNT_W-1:0]   biterror_counter,
  output logic [CNT_W-1:0]   decoder_Code_counter,
  output logic [CNT_W-1:0]   frame_error_counter,
  output logic               decoder_sigma_down,
  output logic               sweep_done,
  output logic               overrun
);

  localparam int NCH     = CodeLen / Chunk;
  localparam int PC_W    = $clog2(Chunk + 1);
  localparam int FE_W    = $clog2(CodeLen + 1);
  localparam int TMR_MAX = (NCH > Rst_Cycles) ? NCH : Rst_Cycles;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PT_W    = $clog2(Sigma_Iteration_Times + 1);

  state_t               r_state, w_next;
  logic                 r_dd;
  logic [CodeLen-1:0]   r_err_vec;
  logic [FE_W-1:0]      r_frame_err;
  logic [TMR_W-1:0]     r_timer;
  logic [CNT_W-1:0]     r_bit, r_code, r_ferr;
  logic [SIGMA_W-1:0]   r_sigma;
  logic [PT_W-1:0]      r_point;
  logic                 r_overrun;
  logic                 w_frame, w_busy, w_close, w_last, w_tc;
  logic [PC_W-1:0]      w_pop;

  assign w_frame = decoder_down & ~r_dd;
  assign w_busy  = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_tc    = (r_timer == '0);
  assign w_close = (r_code == CNT_W'(Frames_Per_Sigma)) || (r_bit >= CNT_W'(Err_Target));
  assign w_last  = (r_point == PT_W'(Sigma_Iteration_Times - 1));

  ber_popcount #(.W(Chunk)) u_popcount (
    .i_bits  (r_err_vec[Chunk-1:0]),
    .o_count (w_pop)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_frame) w_next = S_COUNT;
      S_COUNT:   if (w_tc) w_next = S_ACCUM;
      S_ACCUM:   w_next = S_CHECK;
      S_CHECK:   w_next = w_close ? S_REPORT : S_IDLE;
      S_REPORT:  w_next = w_last ? S_DONE : S_RESTART;
      S_RESTART: if (w_tc) w_next = S_IDLE;
      S_DONE:    w_next = S_DONE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dd        <= 1'b0;
      r_err_vec   <= '0;
      r_frame_err <= '0;
      r_timer     <= '0;
      r_bit       <= '0;
      r_code      <= '0;
      r_ferr      <= '0;
      r_sigma     <= Sigma_Start;
      r_point     <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_dd <= decoder_down;
      if (w_frame && w_busy) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (w_frame) begin
          r_err_vec   <= prototype_sequence ^ decision_information;
          r_frame_err <= '0;
          r_timer     <= TMR_W'(NCH - 1);
        end
        S_COUNT: begin
          // shifting keeps the popcount input fixed on the low chunk
          r_frame_err <= r_frame_err + FE_W'(w_pop);
          r_err_vec   <= r_err_vec >> Chunk;
          r_timer     <= r_timer - 1'b1;
        end
        S_ACCUM: begin
          r_bit  <= sat_add(r_bit, CNT_W'(r_frame_err));
          r_code <= sat_add(r_code, CNT_W'(1));
          r_ferr <= sat_add(r_ferr, CNT_W'(r_frame_err != '0));
        end
        S_REPORT: if (!w_last) begin
          r_sigma <= (r_sigma < Sigma_Step) ? '0 : r_sigma - Sigma_Step;
          r_point <= r_point + 1'b1;
          r_timer <= TMR_W'(Rst_Cycles - 1);
        end
        S_RESTART: begin
          r_timer <= r_timer - 1'b1;
          if (w_tc) begin
            r_bit  <= '0;
            r_code <= '0;
            r_ferr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign sigma                = r_sigma;
  assign modulation_rst       = (r_state != S_RESTART);
  assign biterror_counter     = r_bit;
  assign decoder_Code_counter = r_code;
  assign frame_error_counter  = r_ferr;
  assign decoder_sigma_down   = (r_state == S_REPORT);
  assign sweep_done           = (r_state == S_DONE);
  assign overrun              = r_overrun;

endmodule

// File: tb/tb_ber_statistics.sv
// Directed plus randomized bench for ber_statistics, two configurations side by side.
module tb_ber_statistics;

  logic         clk = 1'b0;
  logic         rst_a = 1'b0, rst_b = 1'b0;
  logic         dd_a = 1'b0, dd_b = 1'b0;
  logic [255:0] proto = '0, dec = '0;

  logic [9:0]  sigma_a, sigma_b;
  logic        mrst_a, mrst_b, sd_a, sd_b, done_a, done_b, ovr_a, ovr_b;
  logic [31:0] bit_a, code_a, ferr_a, bit_b, code_b, ferr_b;

  int checks = 0;
  int errors = 0;

  // configuration of each instance, index 0 = u_a, 1 = u_b
  int cfg_f[2]     = '{4, 1000};
  int cfg_e[2]     = '{100, 10};
  int cfg_it[2]    = '{20, 2};
  int cfg_start[2] = '{600, 5};
  int cfg_step[2]  = '{25, 8};
  localparam int RST_CYC = 4;

  longint m_bit[2], m_code[2], m_ferr[2];
  int     m_sigma[2], m_point[2];
  bit     m_done[2], m_ovr[2];

  int          pulses[2], lows[2];
  logic [31:0] cap_bit[2], cap_code[2], cap_ferr[2];

  always #5 clk = ~clk;

  ber_statistics #(
    .Frames_Per_Sigma(4), .Err_Target(100), .Sigma_Iteration_Times(20),
    .Sigma_Start(10'd600), .Sigma_Step(10'd25), .Rst_Cycles(RST_CYC)
  ) u_a (
    .clk(clk), .rst(rst_a), .decoder_down(dd_a),
    .prototype_sequence(proto), .decision_information(dec),
    .sigma(sigma_a), .modulation_rst(mrst_a),
    .biterror_counter(bit_a), .decoder_Code_counter(code_a), .frame_error_counter(ferr_a),
    .decoder_sigma_down(sd_a), .sweep_done(done_a), .overrun(ovr_a)
  );

  ber_statistics #(
    .Frames_Per_Sigma(1000), .Err_Target(10), .Sigma_Iteration_Times(2),
    .Sigma_Start(10'd5), .Sigma_Step(10'd8), .Rst_Cycles(RST_CYC)
  ) u_b (
    .clk(clk), .rst(rst_b), .decoder_down(dd_b),
    .prototype_sequence(proto), .decision_information(dec),
    .sigma(sigma_b), .modulation_rst(mrst_b),
    .biterror_counter(bit_b), .decoder_Code_counter(code_b), .frame_error_counter(ferr_b),
    .decoder_sigma_down(sd_b), .sweep_done(done_b), .overrun(ovr_b)
  );

  always @(negedge clk) begin
    if (sd_a === 1'b1) begin
      pulses[0]++; cap_bit[0] = bit_a; cap_code[0] = code_a; cap_ferr[0] = ferr_a;
    end
    if (sd_b === 1'b1) begin
      pulses[1]++; cap_bit[1] = bit_b; cap_code[1] = code_b; cap_ferr[1] = ferr_b;
    end
    if (mrst_a === 1'b0) lows[0]++;
    if (mrst_b === 1'b0) lows[1]++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int s);
    m_bit[s] = 0; m_code[s] = 0; m_ferr[s] = 0;
    m_sigma[s] = cfg_start[s]; m_point[s] = 0;
    m_done[s] = 1'b0; m_ovr[s] = 1'b0;
  endtask

  task automatic check_state(input int s, input string tag);
    check({tag, " bit"},   s ? bit_b : bit_a,   64'(m_bit[s]));
    check({tag, " code"},  s ? code_b : code_a, 64'(m_code[s]));
    check({tag, " ferr"},  s ? ferr_b : ferr_a, 64'(m_ferr[s]));
    check({tag, " sigma"}, s ? sigma_b : sigma_a, 64'(m_sigma[s]));
    check({tag, " mrst"},  s ? mrst_b : mrst_a, 64'(1));
    check({tag, " sdown"}, s ? sd_b : sd_a,     64'(0));
    check({tag, " done"},  s ? done_b : done_a, 64'(m_done[s]));
    check({tag, " ovr"},   s ? ovr_b : ovr_a,   64'(m_ovr[s]));
  endtask

  task automatic set_dd(input int s, input logic v);
    if (s == 0) dd_a = v; else dd_b = v;
  endtask

  task automatic run_frame(input int s, input logic [255:0] p, input logic [255:0] d,
                           input bit overlap, input string tag);
    int  e;
    bit  close;
    int  exp_pulses, exp_lows;
    pulses[s] = 0; lows[s] = 0;
    @(negedge clk);
    proto = p; dec = d;
    set_dd(s, 1'b1);
    @(negedge clk);
    set_dd(s, 1'b0);
    if (overlap) begin
      @(negedge clk);
      set_dd(s, 1'b1);
      @(negedge clk);
      set_dd(s, 1'b0);
    end
    repeat (16) @(negedge clk);

    exp_pulses = 0; exp_lows = 0;
    if (!m_done[s]) begin
      if (overlap) m_ovr[s] = 1'b1;
      e = $countones(p ^ d);
      m_bit[s]  = (m_bit[s] + e > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_bit[s] + e;
      m_code[s] = m_code[s] + 1;
      m_ferr[s] = m_ferr[s] + ((e != 0) ? 1 : 0);
      close = (m_code[s] == cfg_f[s]) || (m_bit[s] >= cfg_e[s]);
      if (close) begin
        exp_pulses = 1;
        check({tag, " cap bit"},  cap_bit[s],  64'(m_bit[s]));
        check({tag, " cap code"}, cap_code[s], 64'(m_code[s]));
        check({tag, " cap ferr"}, cap_ferr[s], 64'(m_ferr[s]));
        if (m_point[s] == cfg_it[s] - 1) begin
          m_done[s] = 1'b1;
        end else begin
          exp_lows = RST_CYC;
          m_sigma[s] = (m_sigma[s] < cfg_step[s]) ? 0 : m_sigma[s] - cfg_step[s];
          m_point[s]++;
          m_bit[s] = 0; m_code[s] = 0; m_ferr[s] = 0;
        end
      end
    end
    check({tag, " pulses"}, 64'(pulses[s]), 64'(exp_pulses));
    check({tag, " rstlow"}, 64'(lows[s]), 64'(exp_lows));
    check_state(s, tag);
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [255:0] rand_mask(input int maxflips);
    logic [255:0] m;
    int n;
    m = '0;
    n = $urandom_range(0, maxflips);
    if ($urandom_range(0, 3) == 0) n = 0;
    for (int i = 0; i < n; i++) m[$urandom_range(0, 255)] = 1'b1;
    return m;
  endfunction

  initial begin
    logic [255:0] p, m;

    // reset both instances
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    model_reset(0); model_reset(1);
    check_state(0, "reset_a");
    check_state(1, "reset_b");

    // three isolated bit errors in one frame, LSB/MSB boundaries included
    p = rand_vec();
    m = '0; m[0] = 1'b1; m[100] = 1'b1; m[255] = 1'b1;
    run_frame(0, p, p ^ m, 1'b0, "three_err");
    check("three_err bit=3", bit_a, 64'd3);

    // four clean frames close the point on the frame target
    @(negedge clk); rst_a = 1'b0; @(negedge clk); rst_a = 1'b1;
    model_reset(0);
    for (int i = 0; i < 4; i++) begin
      p = rand_vec();
      run_frame(0, p, p, 1'b0, "clean");
    end
    check("clean sigma=575", sigma_a, 64'd575);

    // random error patterns, some frames with a second edge during COUNT
    for (int i = 0; i < 24; i++) begin
      p = rand_vec();
      m = rand_mask(40);
      run_frame(0, p, p ^ m, (i % 5) == 2, "rand");
    end
    check("rand overrun sticky", ovr_a, 64'd1);

    // reset in the 4th COUNT cycle discards the in-flight frame
    @(negedge clk);
    proto = rand_vec(); dec = ~proto;
    dd_a = 1'b1;
    @(negedge clk);
    dd_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    model_reset(0);
    check_state(0, "midrst");
    rst_a = 1'b1;
    repeat (12) @(negedge clk);
    check_state(0, "midrst_after");
    p = rand_vec(); m = '0; m[31] = 1'b1; m[32] = 1'b1;
    run_frame(0, p, p ^ m, 1'b0, "postrst");
    check("postrst code=1", code_a, 64'd1);

    // error target closes after one fully inverted frame; sigma clamps to 0
    p = rand_vec();
    run_frame(1, p, ~p, 1'b0, "inv1");
    check("inv1 cap bit=256", cap_bit[1], 64'd256);
    check("inv1 sigma=0", sigma_b, 64'd0);

    // last point: no restart pulse, sweep_done sticks
    p = rand_vec();
    run_frame(1, p, ~p, 1'b0, "inv2");
    check("inv2 done", done_b, 64'd1);

    // frames after the sweep are ignored and do not flag overrun
    p = rand_vec();
    run_frame(1, p, p ^ rand_mask(20), 1'b1, "after_done");
    check("after_done cap code", cap_code[1], 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
